// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control types and constants
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         CNT_W_DEF = 32;

    // Load in EX whose destination is read by the instruction in ID; $zero never hazards
    function automatic logic load_use(
        input logic       ex_memread,
        input logic [4:0] ex_rtaddr,
        input logic [4:0] id_rsaddr,
        input logic [4:0] id_rtaddr,
        input logic       id_uses_rt
    );
        return ex_memread && (ex_rtaddr != REG_ZERO) &&
               ((ex_rtaddr == id_rsaddr) || (id_uses_rt && (ex_rtaddr == id_rtaddr)));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - hazard unit operand/control bundle
interface hazard_unit_if #(
    parameter int CNT_W = pipe_pkg::CNT_W_DEF
);
    logic             ex_memread_i;
    logic [4:0]       ex_rtaddr_i;
    logic [4:0]       id_rsaddr_i;
    logic [4:0]       id_rtaddr_i;
    logic             id_uses_rt_i;
    logic             branch_taken_i;
    logic             dmem_wait_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_hold_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Pipeline side: publishes stage fields, consumes controls
    modport master (
        output ex_memread_i, ex_rtaddr_i, id_rsaddr_i, id_rtaddr_i, id_uses_rt_i,
               branch_taken_i, dmem_wait_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               stall_cnt_o, flush_cnt_o
    );

    // Hazard unit side
    modport slave (
        input  ex_memread_i, ex_rtaddr_i, id_rsaddr_i, id_rtaddr_i, id_uses_rt_i,
               branch_taken_i, dmem_wait_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    // Count qualifying cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (inc_i && (q_o != {W{1'b1}})) begin
            q_o <= q_o + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and memory-wait freeze control
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_unit_if.slave hz
);

    localparam int                REM_W    = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [REM_W-1:0]  REM_INIT = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);

    pipe_state_e      state_q, state_d;
    pipe_state_e      ret_q, ret_d;
    pipe_state_e      eff_state;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             lu;
    logic             stall_inc;
    logic             flush_inc;

    assign lu = load_use(hz.ex_memread_i, hz.ex_rtaddr_i, hz.id_rsaddr_i,
                         hz.id_rtaddr_i, hz.id_uses_rt_i);

    // Once memory is ready again, act as the saved state in that same cycle
    assign eff_state = ((state_q == ST_WAIT) && !hz.dmem_wait_i) ? ret_q : state_q;

    // Next-state and Mealy control outputs
    always_comb begin
        hz.pc_write_o    = 1'b1;
        hz.ifid_write_o  = 1'b1;
        hz.ifid_flush_o  = 1'b0;
        hz.idex_bubble_o = 1'b0;
        hz.pipe_hold_o   = 1'b0;
        state_d          = state_q;
        ret_d            = ret_q;
        rem_d            = rem_q;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;

        if (rst_i) begin
            hz.pc_write_o    = 1'b0;
            hz.ifid_write_o  = 1'b0;
            hz.ifid_flush_o  = 1'b1;
            hz.idex_bubble_o = 1'b1;
        end else if (hz.dmem_wait_i) begin
            hz.pc_write_o   = 1'b0;
            hz.ifid_write_o = 1'b0;
            hz.pipe_hold_o  = 1'b1;
            state_d         = ST_WAIT;
            if (state_q != ST_WAIT) begin
                ret_d = (state_q == ST_FLUSH) ? ST_FLUSH : ST_RUN;
            end
        end else begin
            case (eff_state)
                ST_FLUSH: begin
                    // ID holds a squashed NOP, so hazards and branches are moot here
                    hz.ifid_flush_o = 1'b1;
                    flush_inc       = 1'b1;
                    rem_d           = rem_q - 1'b1;
                    state_d         = (rem_q == REM_ONE) ? ST_RUN : ST_FLUSH;
                end
                default: begin
                    state_d = ST_RUN;
                    if (lu) begin
                        hz.pc_write_o    = 1'b0;
                        hz.ifid_write_o  = 1'b0;
                        hz.idex_bubble_o = 1'b1;
                        stall_inc        = 1'b1;
                    end else if (hz.branch_taken_i) begin
                        hz.ifid_flush_o = 1'b1;
                        flush_inc       = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            rem_d   = REM_INIT;
                        end
                    end
                end
            endcase
        end
    end

    // State, return and remaining-flush registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .q_o   (hz.stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .q_o   (hz.flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

    localparam int FC    = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    localparam logic [4:0] C_DEF = 5'b11000;
    localparam logic [4:0] C_STL = 5'b00010;
    localparam logic [4:0] C_FL  = 5'b11100;
    localparam logic [4:0] C_HLD = 5'b00001;
    localparam logic [4:0] C_RST = 5'b00110;

    typedef struct {
        logic          rst;
        logic          mr;
        logic [4:0]    exrt;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic          urt;
        logic          tk;
        logic          wt;
        logic [4:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   m_left = 0;
    int   m_sc   = 0;
    int   m_fc   = 0;

    vec_t tbl[$];

    hazard_unit_if #(.CNT_W(CW)) hz ();

    hazard_unit #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic mr, input int exrt, input int rs,
                                input int rt, input logic urt, input logic tk, input logic wt,
                                input logic [4:0] ctl, input int sc, input int fc);
        vec_t v;
        v.rst = r; v.mr = mr; v.exrt = 5'(exrt); v.rs = 5'(rs); v.rt = 5'(rt);
        v.urt = urt; v.tk = tk; v.wt = wt; v.ctl = ctl; v.sc = CW'(sc); v.fc = CW'(fc);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; reference model always advances, expectations come from
    // the model (use_model) or from the caller's constants
    task automatic step(input vec_t v, input logic use_model, input string name);
        logic [4:0] mctl;
        logic       lu;
        logic [4:0] act;
        @(negedge clk);
        rst               = v.rst;
        hz.ex_memread_i   = v.mr;
        hz.ex_rtaddr_i    = v.exrt;
        hz.id_rsaddr_i    = v.rs;
        hz.id_rtaddr_i    = v.rt;
        hz.id_uses_rt_i   = v.urt;
        hz.branch_taken_i = v.tk;
        hz.dmem_wait_i    = v.wt;

        lu = v.mr && (v.exrt != 0) && ((v.exrt == v.rs) || (v.urt && v.exrt == v.rt));
        if (v.rst) begin
            mctl = C_RST; m_left = 0; m_sc = 0; m_fc = 0;
        end else if (v.wt) begin
            mctl = C_HLD;
        end else if (m_left > 0) begin
            mctl = C_FL; m_left--; m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else if (lu) begin
            mctl = C_STL; m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end else if (v.tk) begin
            mctl = C_FL; m_left = FC - 1; m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end else begin
            mctl = C_DEF;
        end

        #1;
        act = {hz.pc_write_o, hz.ifid_write_o, hz.ifid_flush_o, hz.idex_bubble_o, hz.pipe_hold_o};
        check({name, ".ctl"}, int'(act), use_model ? int'(mctl) : int'(v.ctl));
        @(posedge clk);
        #1;
        check({name, ".stall_cnt"}, int'(hz.stall_cnt_o), use_model ? m_sc : int'(v.sc));
        check({name, ".flush_cnt"}, int'(hz.flush_cnt_o), use_model ? m_fc : int'(v.fc));
    endtask

    initial begin
        vec_t v;
        hz.ex_memread_i = 0; hz.ex_rtaddr_i = 0; hz.id_rsaddr_i = 0; hz.id_rtaddr_i = 0;
        hz.id_uses_rt_i = 0; hz.branch_taken_i = 0; hz.dmem_wait_i = 0;

        //                  rst mr exrt rs rt urt tk wt  ctl    sc fc
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0)); // idle
        tbl.push_back(mk(0, 1, 8, 8, 0, 0, 0, 0, C_STL, 1, 0)); // lu on rs
        tbl.push_back(mk(0, 0, 8, 8, 0, 0, 0, 0, C_DEF, 1, 0)); // bubble in EX
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, C_DEF, 1, 0)); // $zero no hazard
        tbl.push_back(mk(0, 1, 9, 3, 9, 0, 0, 0, C_DEF, 1, 0)); // rt unused
        tbl.push_back(mk(0, 1, 9, 3, 9, 1, 0, 0, C_STL, 2, 0)); // lu on rt
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FL,  2, 1)); // taken
        tbl.push_back(mk(0, 1, 8, 8, 0, 0, 0, 0, C_FL,  2, 2)); // lu ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FL,  2, 3)); // last flush
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 2, 3)); // back to run
        tbl.push_back(mk(0, 1, 5, 5, 0, 0, 1, 0, C_STL, 3, 3)); // branch+lu
        tbl.push_back(mk(0, 0, 5, 5, 0, 0, 1, 0, C_FL,  3, 4)); // branch held
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FL,  3, 5));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, C_HLD, 3, 5)); // mid-flush wait
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_FL,  3, 6)); // flush resumes
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 3, 6));
        tbl.push_back(mk(0, 1, 7, 7, 0, 0, 0, 1, C_HLD, 3, 6)); // wait beats lu
        tbl.push_back(mk(0, 1, 7, 7, 0, 0, 0, 0, C_STL, 4, 6)); // lu re-evaluated
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FL,  4, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, C_HLD, 4, 7)); // wait in flush
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, C_RST, 0, 0)); // reset in wait
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_DEF, 0, 0)); // sequence abandoned

        foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Stall saturation: continuous load-use
        for (int i = 0; i < CMAX + 4; i++)
            step(mk(0, 1, 4, 4, 0, 0, 0, 0, C_STL, 0, 0), 1'b1, $sformatf("sat_lu%0d", i));
        check("stall_saturated", int'(hz.stall_cnt_o), CMAX);

        // Flush saturation: branch held taken
        for (int i = 0; i < CMAX + 4; i++)
            step(mk(0, 0, 0, 0, 0, 0, 1, 0, C_FL, 0, 0), 1'b1, $sformatf("sat_br%0d", i));
        check("flush_saturated", int'(hz.flush_cnt_o), CMAX);

        // Randomized traffic against the model
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0), 1'b1, "rnd_rst");
        for (int i = 0; i < 1500; i++) begin
            v = mk(($urandom_range(0, 99) < 2), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), ($urandom_range(0, 99) < 25),
                   ($urandom_range(0, 99) < 20), C_DEF, 0, 0);
            step(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
